// File: rtl/stack_prog_driver.sv
// stack_prog_driver
//   Host-side program player for the 8-pin stack CPU I/O convention.
//   Buffers a short program of 4-bit words, then drives the CPU input bus
//   {2'b00, word, cpu_rst, cpu_clk}: a reset pulse, one word per CPU clock,
//   and finally samples cpu_io_out[3:0] as the result.
//   Optional feature macro: STACK_PROG_DRIVER_TRACE_EN adds trace_valid /
//   trace_data, a per-word snapshot of the CPU output on the last STEP_HI cycle.
module stack_prog_driver #(
   parameter int DEPTH = 16,
   parameter int AW    = 4,
   parameter int HALF  = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load_valid,
   input  logic [3:0]    load_data,
   output logic          load_ready,
   input  logic          clear,
   input  logic          start,
   output logic          busy,
   output logic          done,
   output logic [3:0]    result,
   output logic [AW:0]   prog_len,
   output logic [7:0]    cpu_io_in,
   input  logic [7:0]    cpu_io_out
`ifdef STACK_PROG_DRIVER_TRACE_EN
   ,
   output logic          trace_valid,
   output logic [3:0]    trace_data
`endif
);

   localparam int            PW       = (HALF > 1) ? $clog2(HALF) : 1;
   localparam logic [PW-1:0] LP_LAST  = PW'(HALF - 1);
   localparam logic [AW:0]   LP_DEPTH = (AW + 1)'(DEPTH);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_RST_HI  = 3'd1;
   localparam logic [2:0] S_RST_LO  = 3'd2;
   localparam logic [2:0] S_STEP_LO = 3'd3;
   localparam logic [2:0] S_STEP_HI = 3'd4;
   localparam logic [2:0] S_CAPTURE = 3'd5;

   logic [2:0]    r_state;
   logic [PW-1:0] r_phase;
   logic [AW:0]   r_idx;
   logic [AW:0]   r_len;
   logic          r_busy;
   logic          r_done;
   logic [3:0]    r_result;
   logic [7:0]    r_io;
   logic          r_load_ready;
   logic [3:0]    r_buf [DEPTH];

   logic [2:0]    w_nxt_state;
   logic [PW-1:0] w_nxt_phase;
   logic [AW:0]   w_nxt_idx;
   logic [AW:0]   w_nxt_len;
   logic          w_nxt_busy;
   logic          w_nxt_done;
   logic [3:0]    w_nxt_result;
   logic [7:0]    w_nxt_io;
   logic          w_nxt_load_ready;
   logic          w_load_acc;
   logic          w_last;
   logic [AW:0]   w_idx_inc;
   logic [3:0]    w_word;
   logic          w_unused_hi;

   assign w_last      = (r_phase == LP_LAST);
   assign w_idx_inc   = r_idx + 1'b1;
   assign w_word      = r_buf[w_nxt_idx[AW-1:0]];
   assign w_unused_hi = ^cpu_io_out[7:4];

   assign load_ready = r_load_ready;
   assign busy       = r_busy;
   assign done       = r_done;
   assign result     = r_result;
   assign prog_len   = r_len;
   assign cpu_io_in  = r_io;

`ifdef STACK_PROG_DRIVER_TRACE_EN
   assign trace_valid = (r_state == S_STEP_HI) && w_last;
   assign trace_data  = cpu_io_out[3:0];
`endif

   // Next-state, phase, index and status decisions for the playback sequencer.
   always_comb begin
      w_nxt_state  = r_state;
      w_nxt_phase  = r_phase;
      w_nxt_idx    = r_idx;
      w_nxt_len    = r_len;
      w_nxt_busy   = r_busy;
      w_nxt_done   = r_done;
      w_nxt_result = r_result;
      w_load_acc   = 1'b0;
      if (r_state != S_IDLE) begin
         w_nxt_phase = w_last ? '0 : r_phase + 1'b1;
      end
      case (r_state)
         S_IDLE: begin
            if (clear) begin
               w_nxt_len    = '0;
               w_nxt_done   = 1'b0;
               w_nxt_result = '0;
            end else begin
               if (load_valid && r_load_ready) begin
                  w_load_acc = 1'b1;
                  w_nxt_len  = r_len + 1'b1;
               end
               // start sees the length including a same-cycle load
               if (start) begin
                  if (w_nxt_len == '0) begin
                     w_nxt_done   = 1'b1;
                     w_nxt_result = '0;
                  end else begin
                     w_nxt_done  = 1'b0;
                     w_nxt_busy  = 1'b1;
                     w_nxt_state = S_RST_HI;
                     w_nxt_phase = '0;
                  end
               end
            end
         end
         S_RST_HI: begin
            if (w_last) w_nxt_state = S_RST_LO;
         end
         S_RST_LO: begin
            if (w_last) begin
               w_nxt_state = S_STEP_LO;
               w_nxt_idx   = '0;
            end
         end
         S_STEP_LO: begin
            if (w_last) w_nxt_state = S_STEP_HI;
         end
         S_STEP_HI: begin
            if (w_last) begin
               w_nxt_idx   = w_idx_inc;
               w_nxt_state = (w_idx_inc == r_len) ? S_CAPTURE : S_STEP_LO;
            end
         end
         S_CAPTURE: begin
            if (w_last) begin
               w_nxt_result = cpu_io_out[3:0];
               w_nxt_done   = 1'b1;
               w_nxt_busy   = 1'b0;
               w_nxt_state  = S_IDLE;
            end
         end
         default: begin
            w_nxt_state = S_IDLE;
            w_nxt_busy  = 1'b0;
            w_nxt_phase = '0;
         end
      endcase
   end

   // CPU bus image for the upcoming state, so every pin is driven from a flop.
   always_comb begin
      w_nxt_io = 8'h00;
      case (w_nxt_state)
         S_RST_HI:  w_nxt_io = 8'h03;
         S_RST_LO:  w_nxt_io = 8'h02;
         S_STEP_LO: w_nxt_io = {2'b00, w_word, 2'b00};
         S_STEP_HI: w_nxt_io = {2'b00, w_word, 2'b01};
         default:   w_nxt_io = 8'h00;
      endcase
      w_nxt_load_ready = (w_nxt_state == S_IDLE) && (w_nxt_len < LP_DEPTH);
   end

   // Sequencer and status registers; reset aborts playback and zeroes the bus.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= S_IDLE;
         r_phase      <= '0;
         r_idx        <= '0;
         r_len        <= '0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_result     <= '0;
         r_io         <= 8'h00;
         r_load_ready <= 1'b0;
      end else begin
         r_state      <= w_nxt_state;
         r_phase      <= w_nxt_phase;
         r_idx        <= w_nxt_idx;
         r_len        <= w_nxt_len;
         r_busy       <= w_nxt_busy;
         r_done       <= w_nxt_done;
         r_result     <= w_nxt_result;
         r_io         <= w_nxt_io;
         r_load_ready <= w_nxt_load_ready;
      end
   end

   // Program buffer: appended in IDLE, contents survive reset and playback.
   always_ff @(posedge clk) begin
      if (w_load_acc) begin
         r_buf[r_len[AW-1:0]] <= load_data;
      end
   end

endmodule
